// File: rtl/dma_pcie_mdma_byp_in_arb.sv
// Round-robin arbiter that shares one MDMA descriptor bypass-in port among
// N_REQ descriptor sources, with a single registered output stage.
module dma_pcie_mdma_byp_in_arb #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DSC_W  = 256,
  parameter int unsigned CIDX_W = 16,
  parameter int unsigned SRC_W  = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_en,
  input  logic [N_REQ*DSC_W-1:0]    req_dsc,
  input  logic [N_REQ*CIDX_W-1:0]   req_cidx,
  input  logic [N_REQ-1:0]          req_vld,
  output logic [N_REQ-1:0]          req_rdy,
  output logic [DSC_W-1:0]          out_dsc,
  output logic [CIDX_W-1:0]         out_cidx,
  output logic [SRC_W-1:0]          out_src,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [31:0]               dsc_cnt
);

  logic [N_REQ-1:0]  elig;
  logic              load;
  logic              found;
  logic              grant;
  logic [SRC_W-1:0]  win;
  logic [SRC_W-1:0]  cand;
  logic [SRC_W:0]    sum;
  logic [SRC_W-1:0]  ptr_nxt;

  logic [DSC_W-1:0]  dsc_arr  [N_REQ];
  logic [CIDX_W-1:0] cidx_arr [N_REQ];

  logic              vld_q;
  logic [DSC_W-1:0]  dsc_q;
  logic [CIDX_W-1:0] cidx_q;
  logic [SRC_W-1:0]  src_q;
  logic [SRC_W-1:0]  ptr_q;
  logic [31:0]       cnt_q;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign dsc_arr[g]  = req_dsc[g*DSC_W +: DSC_W];
    assign cidx_arr[g] = req_cidx[g*CIDX_W +: CIDX_W];
  end

  assign elig = req_vld & req_en;
  assign load = !vld_q | out_rdy;

  // Search offsets 0..N_REQ-1 from ptr; the sum is one bit wider than the
  // index so the modulo reduction is exact for non-power-of-2 N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (SRC_W+1)'(k);
      if (sum >= (SRC_W+1)'(N_REQ)) begin
        sum = sum - (SRC_W+1)'(N_REQ);
      end
      cand = sum[SRC_W-1:0];
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign grant   = rst_n & load & found;
  assign ptr_nxt = (win == SRC_W'(N_REQ-1)) ? '0 : win + 1'b1;

  always_comb begin
    req_rdy = '0;
    if (grant) begin
      req_rdy[win] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      dsc_q  <= '0;
      cidx_q <= '0;
      src_q  <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (vld_q && out_rdy) begin
        cnt_q <= cnt_q + 32'd1;
      end
      if (load) begin
        if (grant) begin
          vld_q  <= 1'b1;
          dsc_q  <= dsc_arr[win];
          cidx_q <= cidx_arr[win];
          src_q  <= win;
          ptr_q  <= ptr_nxt;
        end else begin
          vld_q  <= 1'b0;
        end
      end
    end
  end

  assign out_vld  = vld_q;
  assign out_dsc  = dsc_q;
  assign out_cidx = cidx_q;
  assign out_src  = src_q;
  assign dsc_cnt  = cnt_q;

endmodule
